// File: rtl/vslc_servo_pkg.sv
// rtl/vslc_servo_pkg.sv - shared constants and helpers for the servo scheduler
package vslc_servo_pkg;

    localparam int N_CH_MAX = 4;

    localparam logic [15:0] DIV_DEFAULT  = 16'd99;
    localparam logic [15:0] FREQ_DEFAULT = 16'd1999;

    localparam logic [3:0] ADDR_DIV_LO  = 4'd0;
    localparam logic [3:0] ADDR_DIV_HI  = 4'd1;
    localparam logic [3:0] ADDR_FREQ_LO = 4'd2;
    localparam logic [3:0] ADDR_FREQ_HI = 4'd3;
    localparam logic [3:0] ADDR_MASK    = 4'd4;
    localparam logic [3:0] ADDR_CH_BASE = 4'd8;

    // Isolates the lowest set bit; zero in, zero out.
    function automatic logic [N_CH_MAX-1:0] lowest_set(input logic [N_CH_MAX-1:0] v);
        return v & (~v + {{(N_CH_MAX-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/vslc_servo_if.sv
// rtl/vslc_servo_if.sv - host byte-write port of the servo scheduler
interface vslc_servo_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready, wr_err);
endinterface

// File: rtl/vslc_servo_tick.sv
// rtl/vslc_servo_tick.sv - 16-bit prescaler producing a one-clk tick every div+1 clk
module vslc_servo_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 16'd0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == div);
            cnt  <= (cnt == div) ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/tt_um_jimktrains_vslc_servo_sched.sv
// rtl/tt_um_jimktrains_vslc_servo_sched.sv - shadowed servo config, frame scheduler and enable ramp
module tt_um_jimktrains_vslc_servo_sched
    import vslc_servo_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter logic [15:0] DIV_RST  = DIV_DEFAULT,
    parameter logic [15:0] FREQ_RST = FREQ_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    vslc_servo_if.slave         wr,
    output logic                servo_clk,
    output logic                frame_start,
    output logic [15:0]         servo_freq_val,
    output logic [8*N_CH-1:0]   servo_set_val,
    output logic [8*N_CH-1:0]   servo_reset_val,
    output logic [N_CH-1:0]     servo_enabled,
    output logic                commit_pending
);

    logic [15:0]         sh_div, sh_freq, act_div, act_freq, frame_cnt, div_eff;
    logic [7:0]          sh_set [N_CH];
    logic [7:0]          sh_rst [N_CH];
    logic [7:0]          act_set[N_CH];
    logic [7:0]          act_rst[N_CH];
    logic [N_CH-1:0]     req, en_q, en_next;
    logic [N_CH_MAX-1:0] pend_w, ramp_w;
    logic                tick, commit, wr_fire, in_map, err_q, pending_q;

    assign commit = tick && (frame_cnt == act_freq);

    // The commit tick already counts with the new divider, so the very next period uses it.
    assign div_eff = commit ? sh_div : act_div;

    vslc_servo_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .div  (div_eff),
        .tick (tick)
    );

    assign wr.wr_ready = ~commit;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign in_map      = wr.wr_addr[3] ? ({1'b0, wr.wr_addr[2:1]} < 3'(N_CH))
                                       : (wr.wr_addr <= ADDR_MASK);

    assign pend_w  = N_CH_MAX'(req & ~en_q);
    assign ramp_w  = lowest_set(pend_w);
    assign en_next = en_q | ramp_w[N_CH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_div    <= DIV_RST;
            sh_freq   <= FREQ_RST;
            act_div   <= DIV_RST;
            act_freq  <= FREQ_RST;
            frame_cnt <= 16'd0;
            req       <= '0;
            en_q      <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                sh_set[i]  <= 8'd0;
                sh_rst[i]  <= 8'd0;
                act_set[i] <= 8'd0;
                act_rst[i] <= 8'd0;
            end
        end else begin
            err_q <= wr_fire && !in_map;
            if (tick) begin
                frame_cnt <= commit ? 16'd0 : frame_cnt + 16'd1;
            end
            if (wr_fire && in_map) begin
                pending_q <= 1'b1;
                case (wr.wr_addr)
                    ADDR_DIV_LO:  sh_div[7:0]   <= wr.wr_data;
                    ADDR_DIV_HI:  sh_div[15:8]  <= wr.wr_data;
                    ADDR_FREQ_LO: sh_freq[7:0]  <= wr.wr_data;
                    ADDR_FREQ_HI: sh_freq[15:8] <= wr.wr_data;
                    ADDR_MASK: begin
                        req  <= wr.wr_data[N_CH-1:0];
                        en_q <= en_q & wr.wr_data[N_CH-1:0];
                    end
                    default: begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (wr.wr_addr == ADDR_CH_BASE + 4'(2*i))   sh_set[i] <= wr.wr_data;
                            if (wr.wr_addr == ADDR_CH_BASE + 4'(2*i+1)) sh_rst[i] <= wr.wr_data;
                        end
                    end
                endcase
            end
            // wr_ready is low here, so this never collides with the write path above.
            if (commit) begin
                act_div   <= sh_div;
                act_freq  <= sh_freq;
                en_q      <= en_next;
                pending_q <= |(req & ~en_next);
                for (int i = 0; i < N_CH; i++) begin
                    act_set[i] <= sh_set[i];
                    act_rst[i] <= sh_rst[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign servo_set_val[8*g +: 8]   = act_set[g];
        assign servo_reset_val[8*g +: 8] = act_rst[g];
    end

    assign servo_clk      = tick;
    assign frame_start    = commit;
    assign servo_freq_val = act_freq;
    assign servo_enabled  = en_q;
    assign commit_pending = pending_q;
    assign wr.wr_err      = err_q;

endmodule
